// File: rtl/beeper_pkg.sv
// Shared types and sizing helpers for the tone beeper.
package beeper_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_DIV_W    = 20;
  localparam int DEF_DUR_W    = 16;
  localparam int DEF_TICK_DIV = 100000;

  // Index width that never collapses to zero bits (single channel / single-cycle tick).
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tone_div.sv
// Square-wave divider: wave goes high the cycle after restart and inverts every half_period cycles while en.
// Dropping en clears the wave and counter on the same edge; half_period==0 behaves as 1.
module tone_div
  import beeper_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             en,
  input  logic [DIV_W-1:0] half_period,
  output logic             wave
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wave_q, wave_d;
  logic [DIV_W-1:0] last_cnt;

  assign last_cnt = (half_period == '0) ? '0 : half_period - DIV_W'(1);

  always_comb begin
    cnt_d  = '0;
    wave_d = 1'b0;
    if (restart) begin
      cnt_d  = '0;
      wave_d = 1'b1;
    end else if (en) begin
      // >= rather than == so a counter can never run past its limit and wrap
      if (cnt_q >= last_cnt) begin
        cnt_d  = '0;
        wave_d = ~wave_q;
      end else begin
        cnt_d  = cnt_q + DIV_W'(1);
        wave_d = wave_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/tone_beeper.sv
// Multi-channel fixed-priority tone generator; 1-cycle start latency, lower index preempts, stop aborts.
// Duration is counted in ticks of TICK_DIV cycles; PLAY lasts exactly duration*TICK_DIV cycles.
module tone_beeper
  import beeper_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DIV_W    = DEF_DIV_W,
  parameter int DUR_W    = DEF_DUR_W,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              req,
  input  logic [NUM_CH*DIV_W-1:0]        half_period,
  input  logic [NUM_CH*DUR_W-1:0]        duration,
  input  logic                           stop,
  output logic                           beep,
  output logic                           busy,
  output logic [clog2_min1(NUM_CH)-1:0]  active_ch
);

  localparam int CH_W   = clog2_min1(NUM_CH);
  localparam int TICK_W = clog2_min1(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DIV_W-1:0]  hp_q, hp_d;
  logic [DUR_W-1:0]  rem_q, rem_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              restart;
  logic              div_en;
  logic              wave;

  logic              win_vld;
  logic [CH_W-1:0]   win_idx;
  logic [DIV_W-1:0]  win_hp;
  logic [DUR_W-1:0]  win_dur;
  logic              win_ok;

  // Scan from the top so the lowest set index is the one left standing.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_hp  = '0;
    win_dur = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_idx = CH_W'(i);
        win_hp  = half_period[i*DIV_W +: DIV_W];
        win_dur = duration[i*DUR_W +: DUR_W];
      end
    end
  end

  assign win_ok = win_vld && (win_dur != '0);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    hp_d    = hp_q;
    rem_d   = rem_q;
    tick_d  = tick_q;
    restart = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      tick_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_ok) begin
            state_d = ST_PLAY;
            ch_d    = win_idx;
            hp_d    = win_hp;
            rem_d   = win_dur;
            tick_d  = '0;
            restart = 1'b1;
          end
        end
        ST_PLAY: begin
          // A preempting request beats expiry on the same edge.
          if (win_ok && (win_idx < ch_q)) begin
            ch_d    = win_idx;
            hp_d    = win_hp;
            rem_d   = win_dur;
            tick_d  = '0;
            restart = 1'b1;
          end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            rem_d  = rem_q - DUR_W'(1);
            if (rem_q == DUR_W'(1)) begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Enable follows the next state so the wave is cleared on the edge that leaves PLAY.
  assign div_en = (state_d == ST_PLAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      hp_q    <= '0;
      rem_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      hp_q    <= hp_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
    end
  end

  tone_div #(
    .DIV_W(DIV_W)
  ) u_tone_div (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .en         (div_en),
    .half_period(hp_d),
    .wave       (wave)
  );

  assign beep      = wave;
  assign busy      = (state_q == ST_PLAY);
  assign active_ch = ch_q;

endmodule

// File: tb/tb_tone_beeper.sv
// Scoreboard bench for tone_beeper: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_tone_beeper;

  localparam int NUM_CH   = 2;
  localparam int DIV_W    = 20;
  localparam int DUR_W    = 16;
  localparam int TICK_DIV = 10;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*DIV_W-1:0] half_period;
  logic [NUM_CH*DUR_W-1:0] duration;
  logic                    stop;
  logic                    beep;
  logic                    busy;
  logic [0:0]              active_ch;

  tone_beeper #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .DUR_W   (DUR_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .half_period(half_period),
    .duration   (duration),
    .stop       (stop),
    .beep       (beep),
    .busy       (busy),
    .active_ch  (active_ch)
  );

  typedef struct {
    int    cyc;
    logic  beep;
    logic  busy;
    logic  ch;
    string nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.nm, e.cyc, cyc);
      end else if (beep !== e.beep || busy !== e.busy || active_ch !== e.ch) begin
        n_bad++;
        $display("FAIL %s cyc=%0d: got beep=%b busy=%b ch=%0d, want beep=%b busy=%b ch=%0d",
                 e.nm, cyc, beep, busy, active_ch, e.beep, e.busy, e.ch);
      end
    end
  end

  task automatic expect_at(input int c, input logic b, input logic bs, input logic ch, input string nm);
    exp_t e;
    e.cyc = c; e.beep = b; e.busy = bs; e.ch = ch; e.nm = nm;
    q.push_back(e);
  endtask

  // n cycles of PLAY starting at c0 with half-period hp (already >=1).
  task automatic expect_tone(input int c0, input int n, input int hp, input logic ch, input string nm);
    for (int k = 0; k < n; k++)
      expect_at(c0 + k, ((k / hp) % 2) == 0, 1'b1, ch, nm);
  endtask

  task automatic set_ch(input int i, input int hp, input int dur);
    half_period[i*DIV_W +: DIV_W] = DIV_W'(hp);
    duration[i*DUR_W +: DUR_W]    = DUR_W'(dur);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; req = '0; stop = 1'b0; half_period = '0; duration = '0;
    step(3);
    rst = 1'b0;
    n = cyc;
    expect_at(n + 1, 1'b0, 1'b0, 1'b0, "reset");
    step(2);

    // Single tone, operands changed after start must not matter.
    n = cyc;
    set_ch(0, 3, 2);
    expect_tone(n + 1, 20, 3, 1'b0, "tone");
    expect_at(n + 21, 1'b0, 1'b0, 1'b0, "tone_end");
    req = 2'b01; step(1); req = '0;
    set_ch(0, 7, 9);
    step(22);

    // Preemption by channel 0, later channel-1 request ignored.
    n = cyc;
    set_ch(1, 5, 3); set_ch(0, 2, 1);
    expect_tone(n + 1, 7, 5, 1'b1, "pre_ch1");
    expect_tone(n + 8, 10, 2, 1'b0, "preempt");
    expect_at(n + 18, 1'b0, 1'b0, 1'b0, "pre_end");
    req = 2'b10; step(1); req = '0;
    step(6);
    req = 2'b01; step(1); req = '0;
    step(2);
    req = 2'b10; step(1); req = '0;
    step(10);

    // stop and req in the same idle cycle.
    n = cyc;
    set_ch(0, 3, 2);
    expect_at(n + 1, 1'b0, 1'b0, 1'b0, "stop_req");
    expect_at(n + 2, 1'b0, 1'b0, 1'b0, "stop_req_after");
    req = 2'b01; stop = 1'b1; step(1); req = '0; stop = 1'b0;
    step(2);

    // stop mid-PLAY on channel 1; active_ch holds.
    n = cyc;
    set_ch(1, 3, 2);
    expect_tone(n + 1, 4, 3, 1'b1, "stop_play");
    expect_at(n + 5, 1'b0, 1'b0, 1'b1, "stop_idle");
    expect_at(n + 6, 1'b0, 1'b0, 1'b1, "stop_hold");
    req = 2'b10; step(1); req = '0;
    step(3);
    stop = 1'b1; step(1); stop = 1'b0;
    step(2);

    // Zero duration is ignored.
    n = cyc;
    set_ch(0, 3, 0);
    expect_at(n + 1, 1'b0, 1'b0, 1'b1, "dur_zero");
    expect_at(n + 2, 1'b0, 1'b0, 1'b1, "dur_zero_after");
    req = 2'b01; step(1); req = '0;
    step(2);

    // Zero half-period toggles every cycle.
    n = cyc;
    set_ch(0, 0, 1);
    expect_tone(n + 1, 10, 1, 1'b0, "hp_zero");
    expect_at(n + 11, 1'b0, 1'b0, 1'b0, "hp_zero_end");
    req = 2'b01; step(1); req = '0;
    step(11);

    // Simultaneous requests: channel 0 wins.
    n = cyc;
    set_ch(0, 2, 1); set_ch(1, 9, 1);
    expect_tone(n + 1, 10, 2, 1'b0, "both_req");
    expect_at(n + 11, 1'b0, 1'b0, 1'b0, "both_end");
    req = 2'b11; step(1); req = '0;
    step(11);

    // Expiry with a lower-priority request: dropped.
    n = cyc;
    set_ch(0, 4, 1); set_ch(1, 5, 1);
    expect_tone(n + 1, 10, 4, 1'b0, "exp_a");
    expect_at(n + 11, 1'b0, 1'b0, 1'b0, "exp_drop");
    expect_at(n + 12, 1'b0, 1'b0, 1'b0, "exp_drop_after");
    req = 2'b01; step(1); req = '0;
    step(9);
    req = 2'b10; step(1); req = '0;
    step(2);

    // Expiry with a higher-priority request: restart on channel 0.
    n = cyc;
    set_ch(1, 5, 1); set_ch(0, 1, 1);
    expect_tone(n + 1, 10, 5, 1'b1, "exp_b");
    expect_tone(n + 11, 10, 1, 1'b0, "exp_restart");
    expect_at(n + 21, 1'b0, 1'b0, 1'b0, "exp_restart_end");
    req = 2'b10; step(1); req = '0;
    step(9);
    req = 2'b01; step(1); req = '0;
    step(11);

    // Asynchronous reset mid-tone, then a clean start.
    n = cyc;
    set_ch(1, 3, 5);
    expect_tone(n + 1, 3, 3, 1'b1, "pre_rst");
    req = 2'b10; step(1); req = '0;
    step(2);
    @(posedge clk);
    #2;
    expect_at(cyc, 1'b0, 1'b0, 1'b0, "async_rst");
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    n = cyc;
    set_ch(0, 2, 1);
    expect_tone(n + 1, 10, 2, 1'b0, "post_rst");
    expect_at(n + 11, 1'b0, 1'b0, 1'b0, "post_rst_end");
    req = 2'b01; step(1); req = '0;
    step(13);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.nm, e.cyc, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tone_beeper.md
Name: tone_beeper

Overview:
- Parametrised multi-channel alarm/tone generator running on a single system clock.
- Each channel requests a square-wave tone with its own half-period (in clock cycles) and duration (in ticks).
- A fixed-priority arbiter selects the channel; a higher-priority request preempts the current tone.
- Drives the board buzzer pin and reports which channel is sounding. Sits between the alarm/timer logic and the buzzer output.

Parameters:
- NUM_CH, 2, number of request channels (1..8); channel 0 has the highest priority.
- DIV_W, 20, width of each half-period field.
- DUR_W, 16, width of each duration field, in ticks.
- TICK_DIV, 100000, clock cycles per duration tick (1 ms at 100 MHz); must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req  in  NUM_CH  start pulse per channel; sampled every cycle.
- half_period  in  NUM_CH*DIV_W  channel i occupies bits [i*DIV_W +: DIV_W]; clock cycles per tone half-wave.
- duration  in  NUM_CH*DUR_W  channel i occupies bits [i*DUR_W +: DUR_W]; tone length in ticks.
- stop  in  1  abort any tone.
- beep  out  1  buzzer square wave, registered.
- busy  out  1  high while in PLAY.
- active_ch  out  $clog2(NUM_CH) (min 1)  index of the sounding channel; holds its last value when idle.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; beep=0, busy=0, active_ch=0.
  - All counters cleared.
- State machine, IDLE -> PLAY -> IDLE:
  - Start: in IDLE with any req bit set, the lowest set index wins. Its half_period and duration are latched at that edge.
  - On the following cycle: state=PLAY, busy=1, beep=1, active_ch=index. Latency is 1 cycle.
  - Operands are latched, so input changes after the start edge have no effect.
  - Zero duration: a winning channel with duration==0 is ignored and the block stays IDLE.
  - Zero half-period: half_period==0 is treated as 1.
- Tone generation:
  - A half-wave counter counts clock cycles in PLAY.
  - beep inverts after every half_period cycles, so the tone period is 2*half_period.
  - Example: half_period=3 gives beep 1,1,1,0,0,0,...
- Duration:
  - A tick counter runs 0..TICK_DIV-1 from the start cycle. Each wrap decrements the remaining duration.
  - When remaining duration reaches 0, the next state is IDLE: beep=0, busy=0.
  - PLAY therefore lasts exactly duration*TICK_DIV cycles.
- Preemption:
  - In PLAY, a req on an index strictly lower than active_ch restarts the tone with the new channel's operands.
  - On restart, all counters reset and beep=1 on the next cycle.
  - req on the same or a higher index is ignored. There is no queueing.
- stop:
  - In any state, stop forces IDLE on the next cycle with beep=0.
  - stop wins over req in the same cycle.
- Simultaneous events:
  - Duration expiry and a higher-priority req in the same cycle: the req wins and the tone restarts.
  - Expiry and a same-or-lower-priority req in the same cycle: go to IDLE; that req is dropped.
- Widths: all counters are unsigned and sized to their field. The half-wave counter never wraps, because it is compared with >= and then cleared.
- Reset mid-operation: immediate return to reset values. No request is retained.

Decomposition:
- Package beeper_pkg holds:
  - the state typedef (ST_IDLE, ST_PLAY);
  - the function for the active_ch width;
  - default parameter constants.
- One sub-module, tone_div:
  - inputs: clk, rst, restart, en, half_period;
  - output: the registered square wave;
  - instantiated once and reused by the arbiter FSM.
- The tick/duration counter stays in the top level.

Test Plan:
- Bench parameters for all scenarios: NUM_CH=2, TICK_DIV=10.
- Reset mid-tone: assert rst mid-PLAY -> beep, busy and active_ch go to 0 immediately (asynchronous). A req after release starts cleanly.
- Single tone: req=01, half_period0=3, duration0=2 -> busy=1 one cycle later; beep pattern 111000 repeats for exactly 20 cycles, then beep=0, busy=0.
- Preemption: channel 1 playing (half_period1=5); pulse req=01 at cycle 7 -> next cycle active_ch=0, beep=1, counters restarted. A later req=10 is ignored.
- stop with req: same-cycle stop=1 and req=01 while idle -> the block stays IDLE with beep=0. stop mid-PLAY -> IDLE next cycle.
- Edge operands: duration0=0 -> never busy. half_period0=0 -> beep toggles every cycle. Simultaneous req=11 -> channel 0 selected.
- Expiry race: req=10 in the same cycle as channel 0 expires -> IDLE, request dropped. req=01 during channel 1's expiry cycle -> restart on channel 0.
